// File: rtl/store_write_buffer_pkg.sv
// Shared definitions for the posted-store write buffer: drain FSM encodings and default depth.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package store_write_buffer_pkg;

    // Default number of buffered stores.
    localparam int WB_DEPTH = 4;

    // Drain FSM encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TRIG = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_BUSY = 2'd3;

    // A store completes on the first ACK/BUSY cycle where the memory side is not busy.
    function automatic logic drain_done(input logic [1:0] st, input logic busy);
        return ((st == ST_ACK) || (st == ST_BUSY)) && !busy;
    endfunction

endpackage

// File: rtl/store_write_buffer_entry_store.sv
// Entry array for the write buffer: DEPTH x {addr, data, byte} with write port, head read and load-hit compare.
// Latency: write visible next cycle; head read and chk_hit are combinational.
// Backpressure: none; the caller only writes when a slot is free.
//
// Ports:
//   sysclk                      clock
//   wr_en/wr_ptr/wr_addr/...    write one entry at wr_ptr
//   rd_ptr, count               define which entries are live (rd_ptr .. rd_ptr+count-1, modulo DEPTH)
//   head_addr/data/byte         entry[rd_ptr]
//   chk_addr, chk_hit           word-address match against any live entry
module store_write_buffer_entry_store #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          sysclk,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_ptr,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_byte,
    input  logic [PW-1:0] rd_ptr,
    input  logic [PW:0]   count,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          head_byte,
    input  logic [AW-1:0] chk_addr,
    output logic          chk_hit
);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic          byte_q [DEPTH];

    // Byte lanes are deliberately ignored by the load check.
    logic chk_lsb_unused;
    assign chk_lsb_unused = ^chk_addr[1:0];

    // Storage needs no reset: liveness is defined purely by rd_ptr/count.
    always_ff @(posedge sysclk) begin
        if (wr_en) begin
            addr_q[wr_ptr] <= wr_addr;
            data_q[wr_ptr] <= wr_data;
            byte_q[wr_ptr] <= wr_byte;
        end
    end

    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
    assign head_byte = byte_q[rd_ptr];

    // Entry i is live when its distance from the head (modulo DEPTH) is below count.
    // The head entry stays live while it drains, so a load to it keeps stalling.
    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(i) - rd_ptr} < count) &&
                (addr_q[i][AW-1:2] == chk_addr[AW-1:2])) begin
                chk_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store FIFO between CPU-side and memory-side couplers; drains in order via trigger/busy.
// Latency: push to mem_st_trigger 2 cycles on an empty buffer; minimum 3 cycles per drained store.
// Backpressure: push while full is dropped and sets sticky overflow; memory side holds a store with mem_st_busy.
//
// Ports:
//   sysclk, reset                      clock, synchronous active-high reset
//   push/push_addr/push_data/push_byte store from the CPU side
//   full, empty, count, overflow       occupancy status; overflow sticky until reset
//   mem_st_trigger/addr/data/byte      head entry offered to the memory side (trigger is a 1-cycle pulse)
//   mem_st_busy                        memory side still working on the store
//   chk_addr, chk_hit                  load address check against pending stores
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [AW-1:0]            push_addr,
    input  logic [DW-1:0]            push_data,
    input  logic                     push_byte,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     mem_st_trigger,
    output logic [AW-1:0]            mem_st_addr,
    output logic [DW-1:0]            mem_st_data,
    output logic                     mem_st_byte,
    input  logic                     mem_st_busy,
    input  logic [AW-1:0]            chk_addr,
    output logic                     chk_hit
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          push_acc;
    logic          pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_acc = push && !full;
    assign pop      = drain_done(state, mem_st_busy);

    // Trigger is decoded from the state register, so it is glitch-free and drops the cycle after reset.
    assign mem_st_trigger = (state == ST_TRIG);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!empty) state_nxt = ST_TRIG;
            ST_TRIG: state_nxt = ST_ACK;
            ST_ACK:  state_nxt = mem_st_busy ? ST_BUSY : ST_IDLE;
            ST_BUSY: if (!mem_st_busy) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pointers are PW bits wide, so increment wraps modulo DEPTH for free.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state    <= ST_IDLE;
        end else begin
            state <= state_nxt;
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_acc) - CW'(pop);
            if (push && full) overflow <= 1'b1;
        end
    end

    store_write_buffer_entry_store #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW),
        .PW    (PW)
    ) u_entries (
        .sysclk    (sysclk),
        .wr_en     (push_acc),
        .wr_ptr    (wr_ptr),
        .wr_addr   (push_addr),
        .wr_data   (push_data),
        .wr_byte   (push_byte),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .head_addr (mem_st_addr),
        .head_data (mem_st_data),
        .head_byte (mem_st_byte),
        .chk_addr  (chk_addr),
        .chk_hit   (chk_hit)
    );

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus random traffic against a queue model.
// Latency: n/a.
// Backpressure: memory side driven with random busy lengths; busy toggled randomly while ignored.
module tb_store_write_buffer;

    localparam int DEPTH = 4;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        push;
    logic [31:0] push_addr;
    logic [31:0] push_data;
    logic        push_byte;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;
    logic        mem_st_trigger;
    logic [31:0] mem_st_addr;
    logic [31:0] mem_st_data;
    logic        mem_st_byte;
    logic        mem_st_busy;
    logic [31:0] chk_addr;
    logic        chk_hit;

    always #5 sysclk = ~sysclk;

    store_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .push           (push),
        .push_addr      (push_addr),
        .push_data      (push_data),
        .push_byte      (push_byte),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .overflow       (overflow),
        .mem_st_trigger (mem_st_trigger),
        .mem_st_addr    (mem_st_addr),
        .mem_st_data    (mem_st_data),
        .mem_st_byte    (mem_st_byte),
        .mem_st_busy    (mem_st_busy),
        .chk_addr       (chk_addr),
        .chk_hit        (chk_hit)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        b;
    } ent_t;

    // pend_q: stores the buffer still holds (head is being drained until it completes).
    // exp_q : scoreboard of stores the memory side should see, in order.
    ent_t pend_q[$];
    ent_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    bit m_ovf;
    bit armed;      // trigger seen; store in flight from the next cycle
    bit draining;   // memory side currently owns the head store
    int busy_left;
    int busy_lo;
    int busy_hi;
    int idle_cnt;   // cycles the buffer had work but nothing in flight

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every trigger pulse must present the oldest outstanding store.
    always @(negedge sysclk) begin : monitor
        ent_t e;
        if (mem_st_trigger === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL trig_unexpected: trigger with no pending store at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("trig_addr", 64'(mem_st_addr), 64'(e.a));
                check("trig_data", 64'(mem_st_data), 64'(e.d));
                check("trig_byte", 64'(mem_st_byte), 64'(e.b));
            end
        end
    end

    // One cycle: account for the edge just taken, check state, then drive the next inputs.
    task automatic step(input bit r, input bit p, input logic [31:0] a, input logic [31:0] d,
                        input bit b, input logic [31:0] c);
        bit   acc;
        bit   popd;
        bit   hit;
        ent_t e;
        @(negedge sysclk);
        if (reset) begin
            pend_q.delete();
            exp_q.delete();
            m_ovf     = 0;
            armed     = 0;
            draining  = 0;
            busy_left = 0;
            idle_cnt  = 0;
        end else begin
            acc  = push && (pend_q.size() < DEPTH);
            popd = draining && !mem_st_busy;
            if (push && !acc) m_ovf = 1;
            if (popd) begin
                void'(pend_q.pop_front());
                draining = 0;
            end
            if (acc) begin
                e.a = push_addr;
                e.d = push_data;
                e.b = push_byte;
                pend_q.push_back(e);
                exp_q.push_back(e);
            end
        end

        check("count", 64'(count), 64'(pend_q.size()));
        check("empty", 64'(empty), 64'(pend_q.size() == 0));
        check("full", 64'(full), 64'(pend_q.size() == DEPTH));
        check("overflow", 64'(overflow), 64'(m_ovf));
        hit = 0;
        foreach (pend_q[i]) if (pend_q[i].a[31:2] == chk_addr[31:2]) hit = 1;
        check("chk_hit", 64'(chk_hit), 64'(hit));
        if (draining && pend_q.size() > 0) begin
            check("head_addr", 64'(mem_st_addr), 64'(pend_q[0].a));
            check("head_data", 64'(mem_st_data), 64'(pend_q[0].d));
        end

        if (armed) begin
            armed     = 0;
            draining  = 1;
            busy_left = $urandom_range(busy_hi, busy_lo);
        end
        if (mem_st_trigger === 1'b1) begin
            check("trig_gap", 64'(idle_cnt), 64'd1);
            check("trig_overlap", 64'({armed, draining}), 64'd0);
            armed    = 1;
            idle_cnt = 0;
        end else if (!armed && !draining && pend_q.size() > 0) begin
            idle_cnt++;
            check("idle_bound", 64'(idle_cnt <= 1), 64'd1);
        end

        reset     = r;
        push      = p;
        push_addr = a;
        push_data = d;
        push_byte = b;
        chk_addr  = c;
        if (draining) begin
            mem_st_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end else begin
            mem_st_busy = 1'($urandom_range(1, 0));
        end
    endtask

    task automatic idle(input int n, input logic [31:0] c);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0, 0, c);
    endtask

    task automatic do_reset();
        step(1, 0, 32'h0, 32'h0, 0, 32'h0);
        step(1, 0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        bit got;
        reset = 1'b1; push = 1'b0; push_addr = '0; push_data = '0; push_byte = 1'b0;
        mem_st_busy = 1'b0; chk_addr = '0;
        m_ovf = 0; armed = 0; draining = 0; busy_left = 0; idle_cnt = 0;
        busy_lo = 3; busy_hi = 3;

        // Single word store, memory busy for 3 cycles.
        do_reset();
        step(0, 1, 32'h100, 32'hDEADBEEF, 0, 32'h100);
        idle(12, 32'h100);

        // Fill to full, overflow on the fifth push, in-order drain.
        busy_lo = 8; busy_hi = 8;
        do_reset();
        step(0, 1, 32'h10, 32'hA0, 0, 32'h14);
        step(0, 1, 32'h14, 32'hA1, 0, 32'h18);
        step(0, 1, 32'h18, 32'hA2, 0, 32'h1C);
        step(0, 1, 32'h1C, 32'hA3, 0, 32'h20);
        step(0, 1, 32'h20, 32'hA4, 0, 32'h20);
        idle(60, 32'h1C);

        // Byte store word-granular hit, cleared after pop.
        busy_lo = 6; busy_hi = 6;
        do_reset();
        step(0, 1, 32'h203, 32'h5A5A5A5A, 1, 32'h200);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'h0, 32'h0, 0, 32'h200);
            step(0, 0, 32'h0, 32'h0, 0, 32'h204);
        end
        idle(10, 32'h200);

        // Zero-wait memory side: pop in ACK, back-to-back stores.
        busy_lo = 0; busy_hi = 0;
        do_reset();
        for (int i = 0; i < 6; i++)
            step(0, 1, 32'h300 + 32'(i * 4), $urandom, 0, 32'h308);
        idle(25, 32'h300);

        // Reset while the memory side holds a store with 3 entries buffered.
        busy_lo = 8; busy_hi = 8;
        do_reset();
        step(0, 1, 32'h400, 32'h1, 0, 32'h400);
        step(0, 1, 32'h404, 32'h2, 0, 32'h400);
        step(0, 1, 32'h408, 32'h3, 0, 32'h400);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            idle(1, 32'h400);
            if (draining && mem_st_busy) got = 1;
        end
        check("reach_busy", 64'(got), 64'd1);
        idle(1, 32'h400);
        check("busy_count", 64'(count), 64'd3);
        step(1, 0, 32'h0, 32'h0, 0, 32'h400);
        idle(12, 32'h400);

        // Random traffic over a small address window to exercise hits, wrap and push+pop.
        busy_lo = 0; busy_hi = 3;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(499, 0) == 0),
                 ($urandom_range(1, 0) == 1),
                 32'($urandom_range(63, 0)),
                 $urandom,
                 1'($urandom_range(1, 0)),
                 32'($urandom_range(63, 0)));
        end
        idle(40, 32'h0);
        check("drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
